mdu_seq: RTL and testbench

Parametrised multi-cycle multiply/divide unit for the pipelined MIPS core, placed in the EX stage next to the ALU. It accepts a 4-bit MDU operation code from the decoder, runs multiplies and divides over a configurable number of cycles, and owns the HI/LO register pair. It supports the multiply-accumulate family (madd/maddu/msub/msubu) and exposes `Busy` for the hazard unit to stall on.

---
 rtl/mdu_seq.sv | 142 ++++++++++++++
 tb/tb_mdu_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit for the EX stage. It owns the HI/LO register pair.
// The result is computed at launch and held in pending registers until the latency counter drains.
module mdu_seq #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [3:0]       MDUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] Out
);

    localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMfhi  = 4'd5;
    localparam logic [3:0] OpMflo  = 4'd6;
    localparam logic [3:0] OpMthi  = 4'd7;
    localparam logic [3:0] OpMtlo  = 4'd8;
    localparam logic [3:0] OpMadd  = 4'd9;
    localparam logic [3:0] OpMaddu = 4'd10;
    localparam logic [3:0] OpMsub  = 4'd11;
    localparam logic [3:0] OpMsubu = 4'd12;

    typedef enum logic {StIdle, StRun} state_e;

    state_e               state_q;
    logic [CntW-1:0]      cnt_q;
    logic [WIDTH-1:0]     hi_q, lo_q, p_hi_q, p_lo_q;

    logic                 is_md, is_div, div_signed;
    logic [2*WIDTH-1:0]   prod_s, prod_u, acc, res;
    logic [WIDTH-1:0]     a_mag, b_mag, div_num, div_den, q_mag, r_mag, quot, rem;

    always_comb begin
        is_md = 1'b0;
        unique case (MDUOp)
            OpMult, OpMultu, OpDiv, OpDivu,
            OpMadd, OpMaddu, OpMsub, OpMsubu: is_md = 1'b1;
            default:                          is_md = 1'b0;
        endcase
        is_div     = (MDUOp == OpDiv) || (MDUOp == OpDivu);
        div_signed = (MDUOp == OpDiv);

        prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
        // Sign-extended operands multiplied mod 2^(2W) yield the signed product.
        prod_s = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};

        // Signed divide works on magnitudes so truncation and remainder sign are explicit.
        a_mag   = A[WIDTH-1] ? -A : A;
        b_mag   = B[WIDTH-1] ? -B : B;
        div_num = div_signed ? a_mag : A;
        div_den = div_signed ? b_mag : B;
        if (div_den == '0) begin
            div_den = {{(WIDTH-1){1'b0}}, 1'b1};
        end
        q_mag = div_num / div_den;
        r_mag = div_num % div_den;
        quot  = (div_signed && (A[WIDTH-1] ^ B[WIDTH-1])) ? -q_mag : q_mag;
        rem   = (div_signed && A[WIDTH-1]) ? -r_mag : r_mag;

        acc = {hi_q, lo_q};
        res = acc;
        case (MDUOp)
            OpMult:         res = prod_s;
            OpMultu:        res = prod_u;
            OpDiv, OpDivu:  res = (B == '0) ? acc : {rem, quot};
            OpMadd:         res = acc + prod_s;
            OpMaddu:        res = acc + prod_u;
            OpMsub:         res = acc - prod_s;
            OpMsubu:        res = acc - prod_u;
            default:        res = acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            Busy    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (Start && is_md) begin
                        p_hi_q  <= res[2*WIDTH-1:WIDTH];
                        p_lo_q  <= res[WIDTH-1:0];
                        cnt_q   <= is_div ? CntW'(DIV_LAT) : CntW'(MULT_LAT);
                        state_q <= StRun;
                        Busy    <= 1'b1;
                    end else if (MDUOp == OpMthi) begin
                        hi_q <= A;
                    end else if (MDUOp == OpMtlo) begin
                        lo_q <= A;
                    end
                end
                StRun: begin
                    // Any Start or MT request arriving here is dropped on purpose.
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        hi_q    <= p_hi_q;
                        lo_q    <= p_lo_q;
                        state_q <= StIdle;
                        Busy    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

    assign HI = hi_q;
    assign LO = lo_q;

    always_comb begin
        Out = '0;
        if (MDUOp == OpMfhi) begin
            Out = hi_q;
        end else if (MDUOp == OpMflo) begin
            Out = lo_q;
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed plus randomized bench for mdu_seq with an arithmetic reference model of HI/LO.
module tb_mdu_seq;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [3:0]  MDUOp;
    logic [31:0] A, B;
    logic        Busy;
    logic [31:0] HI, LO, Out;

    int n_total = 0;
    int n_pass  = 0;
    logic [31:0] m_hi, m_lo;

    mdu_seq #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDUOp (MDUOp),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO),
        .Out   (Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    // Reference result of an md operation on {HI,LO}, from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hilo);
        longint      sa, sb, ps;
        logic [63:0] pu;
        int          ia, ib, iq, ir;
        logic [31:0] q, r;
        sa = $signed(a);
        sb = $signed(b);
        ps = sa * sb;
        pu = {32'd0, a} * {32'd0, b};
        ia = a;
        ib = b;
        case (op)
            4'd1:  return ps;
            4'd2:  return pu;
            4'd3: begin
                if (b == 32'd0) return hilo;
                iq = ia / ib;
                ir = ia % ib;
                q = iq;
                r = ir;
                return {r, q};
            end
            4'd4: begin
                if (b == 32'd0) return hilo;
                q = a / b;
                r = a % b;
                return {r, q};
            end
            4'd9:  return hilo + ps;
            4'd10: return hilo + pu;
            4'd11: return hilo - ps;
            4'd12: return hilo - pu;
            default: return hilo;
        endcase
    endfunction

    task automatic mt(input logic [3:0] op, input logic [31:0] a);
        MDUOp = op;
        A = a;
        tick();
        MDUOp = 4'd0;
        A = 32'd0;
        if (op == 4'd7) m_hi = a;
        else m_lo = a;
        chk("mt_busy", Busy, 0);
        chk("mt_hi", HI, m_hi);
        chk("mt_lo", LO, m_lo);
    endtask

    task automatic chk_out();
        MDUOp = 4'd5;
        #1 chk("out_mfhi", Out, m_hi);
        MDUOp = 4'd6;
        #1 chk("out_mflo", Out, m_lo);
        MDUOp = 4'd0;
        #1 chk("out_none", Out, 0);
    endtask

    // Launch, count busy cycles, optionally inject ignored requests, then compare the commit.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit inject);
        logic [63:0] exp;
        int          lat, bc;
        bit          stale;
        exp = model(op, a, b, {m_hi, m_lo});
        lat = (op == 4'd3 || op == 4'd4) ? 10 : 5;
        Start = 1'b1;
        MDUOp = op;
        A = a;
        B = b;
        tick();
        Start = 1'b0;
        MDUOp = 4'd0;
        A = 32'd0;
        B = 32'd0;
        bc = 0;
        stale = 1'b0;
        while (Busy === 1'b1 && bc < 100) begin
            bc++;
            if (inject && bc == 3) begin
                Start = 1'b1;
                MDUOp = 4'd1;
                A = 32'd3;
                B = 32'd3;
            end else if (inject && bc == 4) begin
                Start = 1'b0;
                MDUOp = 4'd8;
                A = 32'hDEAD_BEEF;
            end else begin
                Start = 1'b0;
                MDUOp = 4'd0;
                A = 32'd0;
                B = 32'd0;
            end
            if (HI !== m_hi || LO !== m_lo) stale = 1'b1;
            tick();
        end
        Start = 1'b0;
        MDUOp = 4'd0;
        {m_hi, m_lo} = exp;
        chk("busy_cycles", bc, lat);
        chk("precommit_stale", stale, 0);
        chk("commit_hi", HI, m_hi);
        chk("commit_lo", LO, m_lo);
    endtask

    initial begin
        logic [3:0]  ops [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10, 4'd11, 4'd12, 4'd7, 4'd8};
        logic [3:0]  op;
        logic [31:0] ra, rb;

        reset = 1'b1;
        Start = 1'b0;
        MDUOp = 4'd0;
        A = 32'd0;
        B = 32'd0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_busy", Busy, 0);
        chk("reset_hi", HI, 0);
        chk("reset_lo", LO, 0);
        chk_out();

        mt(4'd7, 32'h1234_5678);
        mt(4'd8, 32'h9ABC_DEF0);
        chk_out();

        run_op(4'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);
        chk("mult_hi_const", HI, 32'hFFFF_FFFF);
        chk("mult_lo_const", LO, 32'hFFFF_FFF1);
        run_op(4'd2, 32'hFFFF_FFFD, 32'd5, 1'b0);
        chk("multu_hi_const", HI, 32'h0000_0004);
        chk("multu_lo_const", LO, 32'hFFFF_FFF1);
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_hi_const", HI, 32'hFFFF_FFFF);
        chk("div_lo_const", LO, 32'hFFFF_FFFD);
        run_op(4'd4, 32'd7, 32'd2, 1'b0);
        chk("divu_hi_const", HI, 32'd1);
        chk("divu_lo_const", LO, 32'd3);

        mt(4'd7, 32'd0);
        mt(4'd8, 32'hFFFF_FFFF);
        run_op(4'd10, 32'd1, 32'd1, 1'b0);
        chk("maddu_hi_const", HI, 32'd1);
        chk("maddu_lo_const", LO, 32'd0);
        run_op(4'd11, 32'd1, 32'd1, 1'b0);
        chk("msub_hi_const", HI, 32'd0);
        chk("msub_lo_const", LO, 32'hFFFF_FFFF);

        mt(4'd7, 32'hCAFE_0001);
        run_op(4'd3, 32'd5, 32'd0, 1'b1);
        chk("div0_hi_const", HI, 32'hCAFE_0001);
        chk("div0_lo_const", LO, 32'hFFFF_FFFF);
        run_op(4'd9, 32'h8000_0001, 32'h7FFF_FFFF, 1'b1);
        tick();
        chk("after_inject_busy", Busy, 0);

        Start = 1'b1;
        MDUOp = 4'd13;
        A = 32'h1111_1111;
        B = 32'h2222_2222;
        tick();
        Start = 1'b0;
        MDUOp = 4'd0;
        chk("bad_op_busy", Busy, 0);
        chk("bad_op_hi", HI, m_hi);
        chk("bad_op_lo", LO, m_lo);

        Start = 1'b1;
        MDUOp = 4'd1;
        A = 32'd7;
        B = 32'd9;
        tick();
        Start = 1'b0;
        MDUOp = 4'd0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk("midreset_busy", Busy, 0);
        chk("midreset_hi", HI, 0);
        chk("midreset_lo", LO, 0);
        repeat (8) tick();
        chk("postreset_busy", Busy, 0);
        chk("postreset_hilo", {HI, LO}, 0);

        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 9)];
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (op == 4'd3 && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
            if (op == 4'd7 || op == 4'd8) mt(op, ra);
            else run_op(op, ra, rb, i[0]);
            chk_out();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
